// File: rtl/lcd_char_responder_pkg.sv
// rtl/lcd_char_responder_pkg.sv - shared opcode masks, space code, FSM states and AC stepping
package lcd_char_responder_pkg;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  // Instruction class is chosen by the highest set bit of the byte.
  localparam logic [7:0] MASK_DDRAM = 8'h80;
  localparam logic [7:0] MASK_CGRAM = 8'h40;
  localparam logic [7:0] MASK_FUNC  = 8'h20;
  localparam logic [7:0] MASK_SHIFT = 8'h10;
  localparam logic [7:0] MASK_DISP  = 8'h08;
  localparam logic [7:0] MASK_ENTRY = 8'h04;
  localparam logic [7:0] MASK_HOME  = 8'h02;
  localparam logic [7:0] MASK_CLEAR = 8'h01;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISP,
    OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
  } op_t;

  function automatic op_t decode_op(input logic [7:0] d);
    op_t op;
    if      ((d & MASK_DDRAM) != 8'h00) op = OP_DDRAM;
    else if ((d & MASK_CGRAM) != 8'h00) op = OP_CGRAM;
    else if ((d & MASK_FUNC)  != 8'h00) op = OP_FUNC;
    else if ((d & MASK_SHIFT) != 8'h00) op = OP_SHIFT;
    else if ((d & MASK_DISP)  != 8'h00) op = OP_DISP;
    else if ((d & MASK_ENTRY) != 8'h00) op = OP_ENTRY;
    else if ((d & MASK_HOME)  != 8'h00) op = OP_HOME;
    else if ((d & MASK_CLEAR) != 8'h00) op = OP_CLEAR;
    else                                op = OP_NOP;
    return op;
  endfunction

  // AC is {line, col}; stepping past either end of a line wraps the column
  // and moves to the other line.
  function automatic logic [4:0] ac_step(input logic [4:0] ac, input logic inc);
    logic [4:0] r;
    if (inc) r = (ac[3:0] == 4'hF) ? {~ac[4], 4'h0} : {ac[4], ac[3:0] + 4'h1};
    else     r = (ac[3:0] == 4'h0) ? {~ac[4], 4'hF} : {ac[4], ac[3:0] - 4'h1};
    return r;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// rtl/lcd_ddram.sv - 32x8 display RAM, one write port and two registered read ports
// Ports: clk, resetn (active-high sync, clears read registers only),
//        we/waddr/wdata write port, raddr/rdata bus read port, vaddr/vdata view port.
module lcd_ddram (
  input  logic       clk,
  input  logic       resetn,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata,
  input  logic [4:0] vaddr,
  output logic [7:0] vdata
);

  logic [7:0] mem [32];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      rdata <= 8'h00;
      vdata <= 8'h00;
    end else begin
      rdata <= mem[raddr];
      vdata <= mem[vaddr];
    end
  end

endmodule

// File: rtl/lcd_char_responder.sv
// rtl/lcd_char_responder.sv - HD44780-style character LCD bus responder
// Ports: clk, resetn (active-high sync); LCD_E/LCD_RS/LCD_RW/LCD_DATA bus in,
//        lcd_rdata bus read-back; busy, overrun; display/entry/function flags;
//        ddram_addr (line*0x40+col); view_addr/view_char host-side DDRAM view.
module lcd_char_responder
  import lcd_char_responder_pkg::*;
#(
  parameter int E_MIN = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] lcd_rdata,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       two_line,
  output logic [6:0] ddram_addr,
  output logic       overrun,
  input  logic [4:0] view_addr,
  output logic [7:0] view_char
);

  // A strobe needs at least this many sampled high cycles; shorter glitches
  // are dropped (such pulses carry no guarantee anyway).
  localparam logic [7:0] E_QUAL = (E_MIN > 1) ? 8'(E_MIN - 1) : 8'd1;

  state_t     state, state_n;
  logic       e_q, rs_c, rw_c;
  logic [7:0] data_c, e_len;
  logic [4:0] ac, clr_idx;
  logic       cgram_mode, rd_pend;
  logic       strobe, instr_wr, data_wr, data_rd;
  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata, rd_q;
  op_t        op;

  assign strobe     = e_q & ~LCD_E & (e_len >= E_QUAL);
  assign op         = decode_op(data_c);
  assign instr_wr   = strobe & ~rs_c & ~rw_c & (state == ST_IDLE);
  assign data_wr    = strobe &  rs_c & ~rw_c & (state == ST_IDLE) & ~cgram_mode;
  assign data_rd    = strobe &  rs_c &  rw_c & (state == ST_IDLE);
  assign ddram_addr = {ac[4], 2'b00, ac[3:0]};

  always_ff @(posedge clk) begin
    if (resetn) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (instr_wr && op == OP_CLEAR) state_n = ST_CLEAR;
      ST_CLEAR: if (clr_idx == 5'd31) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // The clear sweep owns the write port; bus data writes use it otherwise.
  always_comb begin
    busy      = (state == ST_CLEAR);
    ram_we    = 1'b0;
    ram_waddr = ac;
    ram_wdata = data_c;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_idx;
      ram_wdata = SPACE_CHAR;
    end else if (data_wr) begin
      ram_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      e_q         <= 1'b0;
      e_len       <= 8'h00;
      rs_c        <= 1'b0;
      rw_c        <= 1'b0;
      data_c      <= 8'h00;
      ac          <= 5'd0;
      cgram_mode  <= 1'b0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      entry_inc   <= 1'b1;
      entry_shift <= 1'b0;
      two_line    <= 1'b0;
      overrun     <= 1'b0;
      clr_idx     <= 5'd0;
      rd_pend     <= 1'b0;
      lcd_rdata   <= 8'h00;
    end else begin
      e_q <= LCD_E;
      if (LCD_E) begin
        rs_c   <= LCD_RS;
        rw_c   <= LCD_RW;
        data_c <= LCD_DATA;
        if (e_len != 8'hFF) e_len <= e_len + 8'h01;
      end else begin
        e_len <= 8'h00;
      end

      // Data read: the RAM port registers DDRAM[AC] on the strobe edge, then
      // the byte is moved into lcd_rdata one cycle later.
      rd_pend <= data_rd;
      if (rd_pend)                          lcd_rdata <= rd_q;
      else if (LCD_E && !LCD_RS && LCD_RW)  lcd_rdata <= {busy, ddram_addr};

      if (strobe && !rw_c && busy) overrun <= 1'b1;

      clr_idx <= (state == ST_CLEAR) ? clr_idx + 5'd1 : 5'd0;

      if (state == ST_CLEAR && clr_idx == 5'd31) begin
        ac         <= 5'd0;
        entry_inc  <= 1'b1;
        cgram_mode <= 1'b0;
      end else if (data_wr || data_rd) begin
        ac <= ac_step(ac, entry_inc);
      end else if (instr_wr) begin
        case (op)
          OP_HOME:  ac <= 5'd0;
          OP_ENTRY: begin
            entry_inc   <= data_c[1];
            entry_shift <= data_c[0];
          end
          OP_DISP: begin
            disp_on   <= data_c[2];
            cursor_on <= data_c[1];
            blink_on  <= data_c[0];
          end
          OP_SHIFT: if (!data_c[3]) ac <= ac_step(ac, data_c[2]);
          OP_FUNC:  two_line <= data_c[3];
          OP_CGRAM: cgram_mode <= 1'b1;
          OP_DDRAM: begin
            ac         <= {data_c[6], data_c[3:0]};
            cgram_mode <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  lcd_ddram u_ddram (
    .clk    (clk),
    .resetn (resetn),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .raddr  (ac),
    .rdata  (rd_q),
    .vaddr  (view_addr),
    .vdata  (view_char)
  );

endmodule

// File: tb/tb_lcd_char_responder.sv
// tb/tb_lcd_char_responder.sv - self-checking bench for lcd_char_responder
module tb_lcd_char_responder;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic [4:0] view_addr = 5'd0;
  logic [7:0] lcd_rdata, view_char;
  logic       busy, disp_on, cursor_on, blink_on, entry_inc, entry_shift, two_line, overrun;
  logic [6:0] ddram_addr;

  always #5 clk = ~clk;

  lcd_char_responder #(.E_MIN(2)) dut (
    .clk(clk), .resetn(resetn), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_DATA(LCD_DATA), .lcd_rdata(lcd_rdata), .busy(busy), .disp_on(disp_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc),
    .entry_shift(entry_shift), .two_line(two_line), .ddram_addr(ddram_addr),
    .overrun(overrun), .view_addr(view_addr), .view_char(view_char)
  );

  int n_vec = 0, n_err = 0;

  // Behavioural model: cursor as (line, column), RAM as a plain array,
  // clear as a countdown of remaining busy cycles.
  int         m_line, m_col, m_left;
  bit         m_inc, m_shift, m_two, m_disp, m_cur, m_blink, m_cgram, m_ovr, m_busy_now;
  logic [7:0] m_mem [32];
  bit         m_known [32];
  bit         chk_en = 0, mem_changed = 0, view_valid = 0;
  logic [7:0] view_exp;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check8(name, {7'd0, act}, {7'd0, exp});
  endtask

  function automatic logic [7:0] m_addr();
    return 8'(m_line * 64 + m_col);
  endfunction

  task automatic m_advance(input bit inc);
    if (inc) begin
      m_col++;
      if (m_col == 16) begin m_col = 0; m_line = 1 - m_line; end
    end else begin
      m_col--;
      if (m_col < 0) begin m_col = 15; m_line = 1 - m_line; end
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_col = 0; m_left = 0; m_busy_now = 0;
    m_inc = 1; m_shift = 0; m_two = 0; m_disp = 0; m_cur = 0; m_blink = 0;
    m_cgram = 0; m_ovr = 0;
  endtask

  task automatic model_apply(input bit rs, input bit rw, input logic [7:0] d);
    if (!rw) begin
      if (m_busy_now) m_ovr = 1;
      else if (rs) begin
        if (!m_cgram) begin
          m_mem[m_line*16 + m_col] = d;
          m_known[m_line*16 + m_col] = 1;
          mem_changed = 1;
          m_advance(m_inc);
        end
      end else begin
        if (d >= 8'h80) begin m_line = d[6]; m_col = int'(d[3:0]); m_cgram = 0; end
        else if (d >= 8'h40) m_cgram = 1;
        else if (d >= 8'h20) m_two = d[3];
        else if (d >= 8'h10) begin if (!d[3]) m_advance(d[2]); end
        else if (d >= 8'h08) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
        else if (d >= 8'h04) begin m_inc = d[1]; m_shift = d[0]; end
        else if (d >= 8'h02) begin m_line = 0; m_col = 0; end
        else if (d == 8'h01) m_left = 32;
      end
    end else if (rs && !m_busy_now) begin
      m_advance(m_inc);
    end
  endtask

  // Compare process: outputs are sampled 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (chk_en) begin
        check1("busy", busy, m_left > 0);
        check1("disp_on", disp_on, m_disp);
        check1("cursor_on", cursor_on, m_cur);
        check1("blink_on", blink_on, m_blink);
        check1("entry_inc", entry_inc, m_inc);
        check1("entry_shift", entry_shift, m_shift);
        check1("two_line", two_line, m_two);
        check1("overrun", overrun, m_ovr);
        check8("ddram_addr", {1'b0, ddram_addr}, m_addr());
        if (view_valid) check8("view_char", view_char, view_exp);
      end
      m_busy_now = (m_left > 0);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_line = 0; m_col = 0; m_inc = 1; m_cgram = 0;
          for (int i = 0; i < 32; i++) begin m_mem[i] = 8'h20; m_known[i] = 1; end
          mem_changed = 1;
        end
      end
      #7;
      view_exp   = m_mem[view_addr];
      view_valid = chk_en && (m_left == 0) && !mem_changed && m_known[view_addr];
      mem_changed = 0;
    end
  end

  task automatic xfer(input bit rs, input bit rw, input logic [7:0] d);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_E = 1'b1;
    repeat (2) @(negedge clk);
    LCD_E = 1'b0;
    model_apply(rs, rw, d);
    @(negedge clk);
  endtask

  task automatic write_str(input string s);
    for (int i = 0; i < s.len(); i++) xfer(1'b1, 1'b0, s[i]);
  endtask

  task automatic view_lit(input int a, input logic [7:0] exp);
    @(negedge clk);
    view_addr = 5'(a);
    repeat (2) @(negedge clk);
    check8($sformatf("view[%0d]", a), view_char, exp);
  endtask

  task automatic status_read(output logic [7:0] v);
    @(negedge clk);
    LCD_RS = 1'b0; LCD_RW = 1'b1; LCD_E = 1'b1;
    repeat (2) @(negedge clk);
    v = lcd_rdata;
    LCD_E = 1'b0;
    model_apply(1'b0, 1'b1, 8'h00);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    LCD_E = 1'b0;
    resetn = 1'b1;
    model_reset();
    mem_changed = 1;
    @(negedge clk);
    resetn = 1'b0;
  endtask

  string      word;
  logic [7:0] sv;
  int         nbusy;

  initial begin
    for (int i = 0; i < 32; i++) begin m_mem[i] = 8'h00; m_known[i] = 0; end
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    chk_en = 1;
    check8("reset lcd_rdata", lcd_rdata, 8'h00);
    check8("reset view_char", view_char, 8'h00);
    check8("reset ddram_addr", {1'b0, ddram_addr}, 8'h00);
    check1("reset entry_inc", entry_inc, 1'b1);

    // Function set, display on, entry increment, home, then text.
    xfer(0, 0, 8'h38); xfer(0, 0, 8'h0F); xfer(0, 0, 8'h06); xfer(0, 0, 8'h80);
    word = "digital";
    write_str(word);
    check1("two_line lit", two_line, 1'b1);
    check1("disp_on lit", disp_on, 1'b1);
    check1("blink_on lit", blink_on, 1'b1);
    check8("ddram after digital", {1'b0, ddram_addr}, 8'h07);
    for (int i = 0; i < 7; i++) view_lit(i, word[i]);

    // Data read of location 0, then status read.
    xfer(0, 0, 8'h80);
    xfer(1, 1, 8'h00);
    repeat (2) @(negedge clk);
    check8("data read", lcd_rdata, 8'h64);
    check8("ddram after read", {1'b0, ddram_addr}, 8'h01);
    status_read(sv);
    check8("status idle", sv, 8'h01);

    // Second-line addressing.
    xfer(0, 0, 8'hC2); write_str("hi");
    view_lit(18, 8'h68); view_lit(19, 8'h69);
    check8("ddram after hi", {1'b0, ddram_addr}, 8'h44);

    // Line wrap forward, then backward.
    xfer(0, 0, 8'h8F); write_str("AB");
    view_lit(15, 8'h41); view_lit(16, 8'h42);
    check8("ddram wrap fwd", {1'b0, ddram_addr}, 8'h41);
    xfer(0, 0, 8'h04); xfer(0, 0, 8'h80); xfer(1, 0, 8'h41);
    check8("ddram wrap back", {1'b0, ddram_addr}, 8'h4F);
    xfer(1, 0, 8'h42);
    view_lit(0, 8'h41); view_lit(31, 8'h42);

    // Cursor shifts.
    xfer(0, 0, 8'h06); xfer(0, 0, 8'h80); xfer(0, 0, 8'h10);
    check8("shift left wrap", {1'b0, ddram_addr}, 8'h4F);
    xfer(0, 0, 8'h14);
    check8("shift right wrap", {1'b0, ddram_addr}, 8'h00);
    xfer(0, 0, 8'h18);

    // CGRAM mode discards data.
    xfer(0, 0, 8'h40); xfer(1, 0, 8'h58); xfer(0, 0, 8'h80); xfer(1, 0, 8'h59);
    view_lit(0, 8'h59);
    check8("ddram after Y", {1'b0, ddram_addr}, 8'h01);

    // Clear: busy for exactly 32 cycles, all spaces afterwards.
    xfer(0, 0, 8'h04);
    xfer(0, 0, 8'h01);
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) nbusy++;
      @(negedge clk);
    end
    check8("busy cycles", 8'(nbusy), 8'd32);
    check1("entry_inc after clear", entry_inc, 1'b1);
    for (int i = 0; i < 32; i++) view_lit(i, 8'h20);

    // Write during clear is dropped and flagged.
    xfer(0, 0, 8'h01);
    xfer(1, 0, 8'h5A);
    check1("overrun lit", overrun, 1'b1);
    repeat (40) @(negedge clk);
    view_lit(0, 8'h20);
    check8("ddram after clear", {1'b0, ddram_addr}, 8'h00);

    // Status read mid-clear, then reset abort.
    xfer(0, 0, 8'h0F);
    xfer(0, 0, 8'h01);
    status_read(sv);
    check1("status busy bit", sv[7], 1'b1);
    for (int i = 0; i < 32; i++) m_known[i] = 0;
    do_reset();
    check1("busy after reset", busy, 1'b0);
    check1("disp_on after reset", disp_on, 1'b0);
    check1("overrun after reset", overrun, 1'b0);
    check8("rdata after reset", lcd_rdata, 8'h00);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_char_responder.md
LCD_CHAR_RESPONDER -- requirements
Module: lcd_char_responder

Interface
REQ-001 Parameter: E_MIN, default 2; minimum LCD_E high time in clk cycles that the block is guaranteed to accept.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 resetn  in  1  synchronous, active-high reset (the name is historical; 1 = reset).
REQ-004 LCD_E  in  1  bus enable strobe, asynchronous-slow relative to clk; a transfer completes on its falling edge.
REQ-005 LCD_RS  in  1  0 = instruction/status, 1 = data.
REQ-006 LCD_RW  in  1  0 = write, 1 = read.
REQ-007 LCD_DATA  in  8  write data or instruction.
REQ-008 lcd_rdata  out  8  read-back byte for RW=1 transfers.
REQ-009 busy  out  1  clear operation in progress.
REQ-010 disp_on, cursor_on, blink_on  out  1 each  display control flags.
REQ-011 entry_inc, entry_shift, two_line  out  1 each  entry mode I/D and S flags, function set N flag.
REQ-012 ddram_addr  out  7  address counter as a bus address (line*0x40 + column).
REQ-013 overrun  out  1  sticky; a write arrived while busy.
REQ-014 view_addr  in  5  host-side character index {line, col[3:0]}.
REQ-015 view_char  out  8  DDRAM[view_addr], registered, 1-cycle latency.

Function
REQ-016 LCD_E is registered; a strobe fires in the cycle where the registered E=1 and the current E=0. RS, RW and DATA are captured every cycle that E is high, and the captured copy is used at the strobe.
REQ-017 DDRAM is 32x8: 2 lines x 16 columns. The address counter AC is 5 bits {line, col}.
REQ-018 Instruction writes (RS=0, RW=0) decode on the highest set bit of DATA:
- 0x01 clear;
- 0x02-0x03 home: AC=0, contents kept;
- 0x04-0x07 entry mode: entry_inc=D[1], entry_shift=D[0];
- 0x08-0x0F display control: disp_on=D[2], cursor_on=D[1], blink_on=D[0];
- 0x10-0x1F shift: if D[3]=0, move AC by one (right if D[2]=1, else left) with REQ-021 wrap; if D[3]=1, ignored;
- 0x20-0x3F function set: two_line=D[3], other bits ignored;
- 0x40-0x7F CGRAM address: enter cgram_mode;
- 0x80-0xFF DDRAM address: line=D[6], col=D[3:0], D[5:4] ignored; exit cgram_mode;
- 0x00: no operation.
REQ-019 Clear: FSM IDLE->CLEAR. Writes 0x20 to all 32 locations, one per cycle, index 0..31. busy=1 for exactly 32 cycles starting the cycle after the strobe. Then AC=0, entry_inc=1, cgram_mode exits, FSM returns to IDLE.
REQ-020 Data write (RS=1, RW=0): if cgram_mode, the data is discarded and AC is unchanged. Otherwise DDRAM[AC]=DATA, then AC advances.
REQ-021 AC advance: if entry_inc=1, col+1 with wrap 15->0 and line toggled; if entry_inc=0, col-1 with wrap 0->15 and line toggled. So 0x0F->0x40, 0x4F->0x00, 0x00->0x4F. entry_shift is stored only and has no display effect.
REQ-022 Status read (RS=0, RW=1): lcd_rdata={busy, ddram_addr}, updated every cycle while E is high.
REQ-023 Data read (RS=1, RW=1): at the strobe, lcd_rdata=DDRAM[AC], then AC advances per REQ-021. Nothing is written.
REQ-024 Any write strobe while busy=1 is ignored and sets overrun. Status reads while busy are served normally. Data reads while busy are ignored.
REQ-025 view_char reads through a second DDRAM port. During a clear it returns either 0x20 or the old value for each location, and reads 0x20 once busy falls.
REQ-026 E pulses shorter than E_MIN cycles give no guarantee. The block is not required to decode LCD_E tied to clk.

Reset
REQ-027 With resetn=1 at a clk edge:
- FSM=IDLE, AC=0, cgram_mode=0;
- disp_on=cursor_on=blink_on=0;
- entry_inc=1, entry_shift=0, two_line=0;
- busy=0, overrun=0, lcd_rdata=0x00, view_char=0x00;
- registered E=0, so no strobe fires on the first post-reset cycle.
REQ-028 Reset during a clear aborts the clear immediately. DDRAM contents are not reset and may be partially cleared.

Structure
REQ-029 A shared package holds the instruction opcode masks, the space code 0x20, and the FSM state enum (IDLE, CLEAR).
REQ-030 One sub-module, lcd_ddram: a 32x8 RAM with one synchronous write port, one registered read port for REQ-023, and one registered read port for view.

Verification
REQ-031 Write 0x38, 0x0F, 0x06, 0x80, then "digital" -> two_line=1, disp_on=cursor_on=blink_on=1, entry_inc=1; view 0..6 = "digital"; ddram_addr=0x07.
REQ-032 Write 0xC2 then "hi" -> view 18,19 = 'h','i'; ddram_addr=0x44.
REQ-033 Write 0x8F then 'A','B' -> DDRAM[15]='A', DDRAM[16]='B'; ddram_addr=0x41. Repeat with 0x04 and 0x80 -> second character lands at index 31; AC=0x4F.
REQ-034 Write 0x01, then a data write 3 cycles later -> busy high for 32 cycles; the write is dropped and overrun=1; all view reads return 0x20; ddram_addr=0x00.
REQ-035 Write 0x40 then 'X', then 0x80 then 'Y' -> 'X' is discarded; DDRAM[0]='Y'.
REQ-036 Status read mid-clear returns bit7=1. Assert resetn mid-clear -> busy=0 on the next cycle; all flags at reset values.
